// File: rtl/scan_decoder.sv
// One-hot channel decoder with manual select and prescaled auto-scan.
// Output, Index and Tick are all registered and update on the same edge.
module scan_decoder #(
  parameter int SEL_W      = 2,
  parameter int DIV_W      = 16,
  parameter bit ACTIVE_LOW = 1'b0,
  localparam int OUT_N     = 2**SEL_W
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Enable,
  input  logic             Mode,
  input  logic [SEL_W-1:0] Select,
  input  logic [DIV_W-1:0] Divide,
  output logic [OUT_N-1:0] Output,
  output logic [SEL_W-1:0] Index,
  output logic             Tick
);

  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [OUT_N-1:0] OUT_IDLE = {OUT_N{ACTIVE_LOW}};

  logic [SEL_W-1:0] index_q, index_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             mode_q, mode_d;
  logic [OUT_N-1:0] out_q, out_d;
  logic [OUT_N-1:0] onehot_s;

  // Next scan state; the prescaler only matches on equality, so a shrunk
  // Divide lets it run through all-ones and wrap before advancing.
  always_comb begin
    index_d = index_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    mode_d  = Mode;
    if (!Mode) begin
      index_d = Select;
      presc_d = '0;
    end else if (!mode_q) begin
      index_d = Select;
      presc_d = '0;
    end else if (Enable) begin
      if (presc_q == Divide) begin
        presc_d = '0;
        index_d = index_q + SEL_ONE;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + DIV_ONE;
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // Port pattern is decoded from the next index so it always matches Index.
  always_comb begin
    onehot_s = '0;
    if (Enable) begin
      onehot_s[index_d] = 1'b1;
    end else begin
      onehot_s = '0;
    end
    out_d = onehot_s ^ OUT_IDLE;
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      index_q <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      mode_q  <= 1'b0;
      out_q   <= OUT_IDLE;
    end else begin
      index_q <= index_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
    end
  end

  assign Output = out_q;
  assign Index  = index_q;
  assign Tick   = tick_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: a vector table on a 2-bit active-high
// instance plus hand-written sequences on a 3-bit active-low, 4-bit-prescaler instance.
module tb_scan_decoder;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       en_a, mode_a, en_b, mode_b;
  logic [1:0] sel_a;
  logic [15:0] div_a;
  logic [2:0] sel_b;
  logic [3:0] div_b;
  logic [3:0] out_a;
  logic [1:0] idx_a;
  logic       tick_a;
  logic [7:0] out_b;
  logic [2:0] idx_b;
  logic       tick_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  scan_decoder #(.SEL_W(2), .DIV_W(16), .ACTIVE_LOW(1'b0)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .Enable(en_a), .Mode(mode_a),
    .Select(sel_a), .Divide(div_a), .Output(out_a), .Index(idx_a), .Tick(tick_a)
  );

  scan_decoder #(.SEL_W(3), .DIV_W(4), .ACTIVE_LOW(1'b1)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .Enable(en_b), .Mode(mode_b),
    .Select(sel_b), .Divide(div_b), .Output(out_b), .Index(idx_b), .Tick(tick_b)
  );

  typedef struct {
    logic       en;
    logic       mode;
    logic [1:0] sel;
    logic [15:0] div;
    logic [3:0] out;
    logic [1:0] idx;
    logic       tick;
  } vec_t;

  vec_t vecs[28];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_b(input string name, input logic [2:0] idx, input logic tick);
    logic [7:0] one;
    one = 8'd1;
    check({name, " idx_b"}, {29'd0, idx_b}, {29'd0, idx});
    check({name, " tick_b"}, {31'd0, tick_b}, {31'd0, tick});
    check({name, " out_b"}, {24'd0, out_b}, {24'd0, ~(one << idx)});
  endtask

  initial begin
    //           en    mode  sel   div     out      idx   tick
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 16'd2, 4'b0001, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd1, 16'd2, 4'b0010, 2'd1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 16'd2, 4'b0100, 2'd2, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'd3, 16'd2, 4'b1000, 2'd3, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'd1, 16'd2, 4'b0000, 2'd1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 2'd3, 16'd2, 4'b1000, 2'd3, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 2'd0, 16'd2, 4'b1000, 2'd3, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 2'd0, 16'd2, 4'b1000, 2'd3, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 2'd0, 16'd2, 4'b0001, 2'd0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 2'd0, 16'd2, 4'b0001, 2'd0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 2'd0, 16'd2, 4'b0001, 2'd0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 2'd0, 16'd2, 4'b0010, 2'd1, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 2'd0, 16'd2, 4'b0010, 2'd1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 2'd0, 16'd2, 4'b0000, 2'd1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 2'd0, 16'd2, 4'b0000, 2'd1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 2'd0, 16'd2, 4'b0000, 2'd1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 2'd0, 16'd2, 4'b0000, 2'd1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 2'd0, 16'd2, 4'b0000, 2'd1, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 2'd0, 16'd2, 4'b0010, 2'd1, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 2'd0, 16'd2, 4'b0100, 2'd2, 1'b1};
    vecs[20] = '{1'b1, 1'b1, 2'd0, 16'd2, 4'b0100, 2'd2, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 2'd0, 16'd2, 4'b0100, 2'd2, 1'b0};
    vecs[22] = '{1'b1, 1'b1, 2'd0, 16'd2, 4'b1000, 2'd3, 1'b1};
    vecs[23] = '{1'b1, 1'b1, 2'd0, 16'd2, 4'b1000, 2'd3, 1'b0};
    vecs[24] = '{1'b1, 1'b1, 2'd0, 16'd2, 4'b1000, 2'd3, 1'b0};
    vecs[25] = '{1'b1, 1'b1, 2'd0, 16'd2, 4'b0001, 2'd0, 1'b1};
    vecs[26] = '{1'b1, 1'b0, 2'd2, 16'd2, 4'b0100, 2'd2, 1'b0};
    vecs[27] = '{1'b1, 1'b1, 2'd1, 16'd2, 4'b0010, 2'd1, 1'b0};

    Reset_n = 1'b0;
    en_a = 1'b0; mode_a = 1'b0; sel_a = 2'd0; div_a = 16'd0;
    en_b = 1'b0; mode_b = 1'b0; sel_b = 3'd0; div_b = 4'd0;
    #12;
    check("reset out_a", {28'd0, out_a}, 32'd0);
    check("reset idx_a", {30'd0, idx_a}, 32'd0);
    check("reset tick_a", {31'd0, tick_a}, 32'd0);
    check("reset out_b", {24'd0, out_b}, 32'hff);
    check("reset idx_b", {29'd0, idx_b}, 32'd0);
    #5 Reset_n = 1'b1;

    // Manual decode, scan with wrap, enable freeze, scan->manual->scan
    for (int i = 0; i < 28; i++) begin
      en_a = vecs[i].en; mode_a = vecs[i].mode;
      sel_a = vecs[i].sel; div_a = vecs[i].div;
      edge_sample();
      check($sformatf("vec%0d out", i), {28'd0, out_a}, {28'd0, vecs[i].out});
      check($sformatf("vec%0d idx", i), {30'd0, idx_a}, {30'd0, vecs[i].idx});
      check($sformatf("vec%0d tick", i), {31'd0, tick_a}, {31'd0, vecs[i].tick});
    end

    // Asynchronous reset while Tick is high at Index=2, Mode held through release
    sel_a = 2'd3;
    edge_sample();
    edge_sample();
    edge_sample();
    check("pre-reset idx", {30'd0, idx_a}, 32'd2);
    check("pre-reset tick", {31'd0, tick_a}, 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("async reset idx", {30'd0, idx_a}, 32'd0);
    check("async reset tick", {31'd0, tick_a}, 32'd0);
    check("async reset out", {28'd0, out_a}, 32'd0);
    check("async reset out_b", {24'd0, out_b}, 32'hff);
    #3 Reset_n = 1'b1;
    edge_sample();
    check("restart idx", {30'd0, idx_a}, 32'd3);
    check("restart out", {28'd0, out_a}, 32'h8);
    check("restart tick", {31'd0, tick_a}, 32'd0);
    edge_sample();
    edge_sample();
    check("restart dwell idx", {30'd0, idx_a}, 32'd3);
    edge_sample();
    check("restart adv idx", {30'd0, idx_a}, 32'd0);
    check("restart adv tick", {31'd0, tick_a}, 32'd1);
    en_a = 1'b0; mode_a = 1'b0;

    // Active-low, Divide=0: advance every cycle with Tick held high
    en_b = 1'b1; mode_b = 1'b1; sel_b = 3'd0; div_b = 4'd0;
    edge_sample();
    check_b("div0 entry", 3'd0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      edge_sample();
      check_b($sformatf("div0 step%0d", k), 3'(k % 8), 1'b1);
    end

    // Divide shrinks below the running count: wrap through all-ones first
    mode_b = 1'b0;
    edge_sample();
    check_b("shrink manual", 3'd0, 1'b0);
    mode_b = 1'b1; div_b = 4'd10;
    edge_sample();
    check_b("shrink entry", 3'd0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      edge_sample();
      check_b($sformatf("shrink count%0d", k), 3'd0, 1'b0);
    end
    div_b = 4'd3;
    for (int k = 1; k <= 12; k++) begin
      edge_sample();
      check_b($sformatf("shrink wrap%0d", k), 3'd0, 1'b0);
    end
    edge_sample();
    check_b("shrink advance", 3'd1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 The module SHALL have parameter SEL_W, default 2: select/index width; legal range 1..5.
REQ-002 The module SHALL have derived parameter OUT_N = 2**SEL_W, which is the one-hot output count and is not overridable.
REQ-003 The module SHALL have parameter DIV_W, default 16: prescaler width.
REQ-004 The module SHALL have parameter ACTIVE_LOW, default 0: when 1, every Output bit is inverted at the port.
REQ-005 The module SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port Enable, input, 1 bit: 1 = decoder active; 0 = all outputs inactive and scan frozen.
REQ-008 The module SHALL have port Mode, input, 1 bit: 0 = manual decode of Select; 1 = auto-scan.
REQ-009 The module SHALL have port Select, input, SEL_W bits: channel number used in manual mode and as the scan start point.
REQ-010 The module SHALL have port Divide, input, DIV_W bits: scan dwell; the index advances every Divide+1 enabled cycles.
REQ-011 The module SHALL have port Output, output, OUT_N bits: registered one-hot channel select, polarity per ACTIVE_LOW.
REQ-012 The module SHALL have port Index, output, SEL_W bits: registered current channel number.
REQ-013 The module SHALL have port Tick, output, 1 bit: registered one-cycle pulse on each scan advance.

Function
REQ-014 Decode SHALL be: with Enable=1, the logical output has exactly bit Index set; all other bits are 0.
REQ-015 With Enable=0, the logical output SHALL be all 0, which becomes all 1 at the port when ACTIVE_LOW=1.
REQ-016 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-017 In manual mode (Mode=0), each cycle Index SHALL load Select and the prescaler SHALL hold 0.
REQ-018 In manual mode, Tick SHALL be 0.
REQ-019 In manual mode, Select-to-Output latency SHALL be 1 clock: Output after edge N reflects Select before edge N.
REQ-020 Scan entry SHALL occur on the first edge with Mode=1 following a sampled Mode=0: Index loads Select, the prescaler clears to 0, and Tick=0.
REQ-021 In scan mode with Enable=1, the prescaler SHALL increment each cycle.
REQ-022 In scan mode with Enable=1 and prescaler == Divide, on that edge the prescaler SHALL clear to 0, Index SHALL become Index+1, and Tick SHALL be 1 for exactly that cycle.
REQ-023 Index SHALL wrap: OUT_N-1 advances to 0 with no gap cycle.
REQ-024 Divide=0 SHALL advance Index every enabled cycle, with Tick held high continuously.
REQ-025 If Divide changes mid-dwell to a value below the current prescaler count, the prescaler SHALL continue counting to its all-ones value, wrap to 0, and then compare to Divide again; no advance occurs in between.
REQ-026 In scan mode with Enable=0, the prescaler and Index SHALL hold and Tick SHALL be 0; when Enable returns to 1, the scan resumes from the held state, with no restart.
REQ-027 Output and Index SHALL update on the same edge, so the port never shows a one-hot pattern inconsistent with Index.
REQ-028 A switch from scan to manual mode (Mode 1->0) SHALL take effect on the next edge: Index loads Select.

Reset
REQ-029 When Reset_n=0, asynchronously: Index=0, prescaler=0, Tick=0, and Output inactive (all 0 at the port, or all 1 if ACTIVE_LOW=1).
REQ-030 The stored Mode history SHALL reset to 0, so Mode=1 sampled on the first edge after release is treated as scan entry.
REQ-031 Reset release SHALL be synchronous to Clk; the first state update occurs on the first rising edge with Reset_n=1.
REQ-032 Reset asserted mid-scan SHALL abandon the dwell immediately; after release, the scan restarts per REQ-020.

Verification
REQ-033 Manual decode: SEL_W=2, Mode=0, Enable=1, Select stepped 0,1,2,3 on consecutive cycles -> Output 0001,0010,0100,1000, each one cycle later; Tick stays 0.
REQ-034 Scan with wrap: SEL_W=2, Divide=2, Mode=1 entered with Select=3 -> Index 3,0,1,2,3 with a dwell of 3 cycles each; Tick pulses every 3rd cycle, coincident with each Index change.
REQ-035 Enable freeze: during a scan at Index=1 with prescaler=1, Enable=0 for 5 cycles -> Output=0000, Tick=0, state held; after Enable=1, 1 more cycle elapses before Index=2.
REQ-036 Polarity and Divide=0: ACTIVE_LOW=1, SEL_W=3, Divide=0, scan from 0 -> Output 11111110, 11111101, ... advancing every cycle; Tick constantly 1; reset drives 11111111.
REQ-037 Reset mid-operation: Reset_n pulsed low between clock edges during a scan at Index=2 -> Index=0, Tick=0, Output inactive immediately, without waiting for an edge; Mode=1 held through release -> the scan restarts from Select.
REQ-038 Divide shrink: Divide=10, prescaler reaches 7, then Divide is set to 3 -> no advance until the prescaler wraps through its all-ones value, then advance at count 3.
